// File: rtl/balance_pkg.sv
// Shared types, default coefficients and saturation helper for the gen-2 balance controller.
package balance_pkg;

    typedef enum logic [1:0] {
        OFF,
        RAMP,
        RUN
    } bal_state_e;

    localparam int DEF_P_COEFF         = 14;
    localparam int DEF_D_COEFF         = 20;
    localparam int DEF_I_SHIFT         = 6;
    localparam int DEF_D_DEPTH         = 2;
    localparam int DEF_INTEG_W         = 18;
    localparam int DEF_SPD_W           = 11;
    localparam int DEF_MIN_DUTY        = 980;
    localparam int DEF_LOW_TORQUE_BAND = 70;
    localparam int DEF_GAIN_MULT       = 15;
    localparam int DEF_RAMP_STEP       = 64;
    localparam int DEF_TF_THRESH       = 1536;
    localparam int DEF_TF_CNT          = 4;

    localparam int ERR_W  = 10;
    localparam int DIFF_W = 7;
    localparam int PID_W  = 16;

    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val,
                                                      input int unsigned width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (val > hi)
            sat_signed = hi;
        else if (val < lo)
            sat_signed = lo;
        else
            sat_signed = val;
    endfunction

endpackage

// File: rtl/torque_shaper.sv
// Maps a signed torque to motor speed magnitude and direction, capped by the soft-start limit.
module torque_shaper
    import balance_pkg::*;
#(
    parameter int SPD_W           = DEF_SPD_W,
    parameter int MIN_DUTY        = DEF_MIN_DUTY,
    parameter int LOW_TORQUE_BAND = DEF_LOW_TORQUE_BAND,
    parameter int GAIN_MULT       = DEF_GAIN_MULT
)(
    input  logic signed [PID_W-1:0] i_torque,
    input  logic [SPD_W-1:0]        i_spd_limit,
    output logic [SPD_W-1:0]        o_spd,
    output logic                    o_rev
);
    localparam int SPD_MAX = (1 << SPD_W) - 1;

    logic signed [31:0] w_t;
    logic signed [31:0] w_abs_t;
    logic signed [31:0] w_shaped;
    logic signed [31:0] w_mag;
    logic [SPD_W-1:0]   w_sat;

    assign w_t     = 32'(i_torque);
    assign w_abs_t = (w_t < 0) ? -w_t : w_t;

    always_comb begin
        w_shaped = '0;
        w_mag    = '0;
        w_sat    = '0;
        // Outside the low band a fixed duty offset overcomes motor deadband.
        if (w_abs_t >= LOW_TORQUE_BAND)
            w_shaped = (w_t < 0) ? (w_t - MIN_DUTY) : (w_t + MIN_DUTY);
        else
            w_shaped = w_t * GAIN_MULT;
        o_rev = (w_shaped < 0);
        w_mag = (w_shaped < 0) ? -w_shaped : w_shaped;
        w_sat = (w_mag > SPD_MAX) ? SPD_W'(SPD_MAX) : SPD_W'(w_mag);
        o_spd = (w_sat > i_spd_limit) ? i_spd_limit : w_sat;
    end

endmodule

// File: rtl/balance_cntrl_gen2.sv
// Gen-2 segway balance controller: 2-stage PID pipeline, soft-start ramp, debounced too_fast.
// Optional macro BAL_INTEG_LEAK_EN selects a leaky integrator.
module balance_cntrl_gen2
    import balance_pkg::*;
#(
    parameter int P_COEFF         = DEF_P_COEFF,
    parameter int D_COEFF         = DEF_D_COEFF,
    parameter int I_SHIFT         = DEF_I_SHIFT,
    parameter int D_DEPTH         = DEF_D_DEPTH,
    parameter int INTEG_W         = DEF_INTEG_W,
    parameter int SPD_W           = DEF_SPD_W,
    parameter int MIN_DUTY        = DEF_MIN_DUTY,
    parameter int LOW_TORQUE_BAND = DEF_LOW_TORQUE_BAND,
    parameter int GAIN_MULT       = DEF_GAIN_MULT,
    parameter int RAMP_STEP       = DEF_RAMP_STEP,
    parameter int TF_THRESH       = DEF_TF_THRESH,
    parameter int TF_CNT          = DEF_TF_CNT
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld,
    input  logic signed [15:0] ptch,
    input  logic signed [11:0] ld_cell_diff,
    input  logic               rider_off,
    input  logic               en_steer,
    input  logic               pwr_up,
    output logic [SPD_W-1:0]   lft_spd,
    output logic               lft_rev,
    output logic [SPD_W-1:0]   rght_spd,
    output logic               rght_rev,
    output logic               out_vld,
    output logic               too_fast,
    output logic               ramp_done
);
    localparam int SPD_MAX = (1 << SPD_W) - 1;
    localparam int CNT_W   = $clog2(TF_CNT + 1);

    bal_state_e               r_state;
    bal_state_e               w_state_nxt;
    logic [SPD_W-1:0]         r_spd_limit;
    logic [SPD_W-1:0]         w_lim_nxt;
    logic [SPD_W-1:0]         w_lim_step;

    logic signed [ERR_W-1:0]  w_err;
    logic signed [ERR_W-1:0]  r_hist [D_DEPTH];
    logic signed [31:0]       w_ddiff;
    logic signed [31:0]       w_integ_sum;
    logic signed [INTEG_W-1:0] r_integ;
    logic signed [INTEG_W-1:0] w_integ_nxt;
    logic signed [PID_W-1:0]  r_p;
    logic signed [PID_W-1:0]  r_d;
    logic                     r_s1_vld;

    logic signed [PID_W-1:0]  w_pid;
    logic signed [PID_W-1:0]  w_steer;
    logic signed [PID_W-1:0]  w_lft_t;
    logic signed [PID_W-1:0]  w_rght_t;
    logic [SPD_W-1:0]         w_lft_spd;
    logic [SPD_W-1:0]         w_rght_spd;
    logic                     w_lft_rev;
    logic                     w_rght_rev;
    logic                     w_over;

    logic [SPD_W-1:0]         r_lft_spd;
    logic [SPD_W-1:0]         r_rght_spd;
    logic                     r_lft_rev;
    logic                     r_rght_rev;
    logic                     r_out_vld;
    logic                     r_too_fast;
    logic [CNT_W-1:0]         r_over_cnt;
    logic [CNT_W-1:0]         r_under_cnt;

    // Stage 1: error conditioning, P/D terms and integrator.
    assign w_err   = ERR_W'(sat_signed(32'(ptch), ERR_W));
    assign w_ddiff = sat_signed(32'(w_err) - 32'(r_hist[D_DEPTH-1]), DIFF_W);
`ifdef BAL_INTEG_LEAK_EN
    assign w_integ_sum = 32'(r_integ) + 32'(w_err) - 32'(r_integ >>> 10);
`else
    assign w_integ_sum = 32'(r_integ) + 32'(w_err);
`endif
    assign w_integ_nxt = INTEG_W'(sat_signed(w_integ_sum, INTEG_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p      <= '0;
            r_d      <= '0;
            r_s1_vld <= 1'b0;
            r_integ  <= '0;
            for (int unsigned i = 0; i < D_DEPTH; i++)
                r_hist[i] <= '0;
        end else begin
            r_s1_vld <= vld;
            if (vld) begin
                r_p       <= PID_W'(32'(w_err) * P_COEFF);
                r_d       <= PID_W'(w_ddiff * D_COEFF);
                r_hist[0] <= w_err;
                for (int unsigned i = 1; i < D_DEPTH; i++)
                    r_hist[i] <= r_hist[i-1];
            end
            if (rider_off)
                r_integ <= '0;
            else if (vld)
                r_integ <= w_integ_nxt;
        end
    end

    // Stage 2: PID sum, steering split and shaping.
    assign w_pid    = PID_W'(32'(r_p) + 32'(r_d) + 32'(r_integ >>> I_SHIFT));
    assign w_steer  = en_steer ? PID_W'(ld_cell_diff >>> 3) : '0;
    assign w_lft_t  = w_pid - w_steer;
    assign w_rght_t = w_pid + w_steer;

    torque_shaper #(
        .SPD_W(SPD_W),
        .MIN_DUTY(MIN_DUTY),
        .LOW_TORQUE_BAND(LOW_TORQUE_BAND),
        .GAIN_MULT(GAIN_MULT)
    ) u_lft_shaper (
        .i_torque(w_lft_t),
        .i_spd_limit(r_spd_limit),
        .o_spd(w_lft_spd),
        .o_rev(w_lft_rev)
    );

    torque_shaper #(
        .SPD_W(SPD_W),
        .MIN_DUTY(MIN_DUTY),
        .LOW_TORQUE_BAND(LOW_TORQUE_BAND),
        .GAIN_MULT(GAIN_MULT)
    ) u_rght_shaper (
        .i_torque(w_rght_t),
        .i_spd_limit(r_spd_limit),
        .o_spd(w_rght_spd),
        .o_rev(w_rght_rev)
    );

    assign w_over = (w_lft_spd > SPD_W'(TF_THRESH)) || (w_rght_spd > SPD_W'(TF_THRESH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld   <= 1'b0;
            r_lft_spd   <= '0;
            r_rght_spd  <= '0;
            r_lft_rev   <= 1'b0;
            r_rght_rev  <= 1'b0;
            r_too_fast  <= 1'b0;
            r_over_cnt  <= '0;
            r_under_cnt <= '0;
        end else begin
            r_out_vld <= r_s1_vld;
            // Dropping pwr_up zeroes speed on the same edge; direction is left as it was.
            if (!pwr_up) begin
                r_lft_spd  <= '0;
                r_rght_spd <= '0;
            end else if (r_s1_vld) begin
                r_lft_spd  <= w_lft_spd;
                r_rght_spd <= w_rght_spd;
                r_lft_rev  <= w_lft_rev;
                r_rght_rev <= w_rght_rev;
            end
            if (!pwr_up || r_state == OFF) begin
                r_too_fast  <= 1'b0;
                r_over_cnt  <= '0;
                r_under_cnt <= '0;
            end else if (r_s1_vld) begin
                if (w_over) begin
                    r_under_cnt <= '0;
                    if (int'(r_over_cnt) < TF_CNT)
                        r_over_cnt <= r_over_cnt + CNT_W'(1);
                    if (int'(r_over_cnt) + 1 >= TF_CNT)
                        r_too_fast <= 1'b1;
                end else begin
                    r_over_cnt <= '0;
                    if (int'(r_under_cnt) < TF_CNT)
                        r_under_cnt <= r_under_cnt + CNT_W'(1);
                    if (int'(r_under_cnt) + 1 >= TF_CNT)
                        r_too_fast <= 1'b0;
                end
            end
        end
    end

    // Soft-start FSM. In OFF the limit is always 0, so the step adder also serves the first vld.
    assign w_lim_step = (int'(r_spd_limit) + RAMP_STEP >= SPD_MAX) ? SPD_W'(SPD_MAX)
                                                                   : r_spd_limit + SPD_W'(RAMP_STEP);

    always_comb begin
        w_state_nxt = r_state;
        w_lim_nxt   = r_spd_limit;
        if (!pwr_up) begin
            w_state_nxt = OFF;
            w_lim_nxt   = '0;
        end else begin
            case (r_state)
                OFF, RAMP: begin
                    w_state_nxt = RAMP;
                    if (vld)
                        w_lim_nxt = w_lim_step;
                    if (w_lim_nxt == SPD_W'(SPD_MAX))
                        w_state_nxt = RUN;
                end
                RUN:     w_lim_nxt = SPD_W'(SPD_MAX);
                default: begin
                    w_state_nxt = OFF;
                    w_lim_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= OFF;
            r_spd_limit <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_spd_limit <= w_lim_nxt;
        end
    end

    assign lft_spd   = r_lft_spd;
    assign lft_rev   = r_lft_rev;
    assign rght_spd  = r_rght_spd;
    assign rght_rev  = r_rght_rev;
    assign out_vld   = r_out_vld;
    assign too_fast  = r_too_fast;
    assign ramp_done = (r_state == RUN);

endmodule

// File: doc/balance_cntrl_gen2.md
Name: balance_cntrl_gen2

Overview:
Parametrised, pipelined successor of the segway PID balance controller. Converts inertial pitch samples and load-cell steering difference into left/right motor speed and direction. Adds the following over the previous generation:
- parametrised coefficients and widths
- saturating (clamping) integrator anti-windup
- configurable D-term sample spacing
- a 2-stage pipeline with an output-valid strobe
- a soft-start ramp FSM on pwr_up
- a debounced too_fast flag

Sits between the inertial interface and the motor PWM/drive blocks.

Parameters:
P_COEFF, 14, signed P gain (5-bit signed)
D_COEFF, 20, signed D gain (6-bit signed)
I_SHIFT, 6, integrator right-shift to form I term
D_DEPTH, 2, number of vld samples back used for D difference (1..8)
INTEG_W, 18, integrator register width
SPD_W, 11, motor speed width; max speed = 2^SPD_W-1
MIN_DUTY, 980, duty offset added outside low-torque band
LOW_TORQUE_BAND, 70, |torque| threshold for gain region
GAIN_MULT, 15, low-band torque multiplier
RAMP_STEP, 64, speed-limit increment per vld during soft start
TF_THRESH, 1536, too_fast speed threshold
TF_CNT, 4, consecutive output samples needed to set or clear too_fast

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
vld  in  1  new pitch sample strobe (single-cycle)
ptch  in  16  signed pitch
ld_cell_diff  in  12  signed lft_ld - rght_ld
rider_off  in  1  no rider; clears integrator
en_steer  in  1  apply steering differential
pwr_up  in  1  enable drive; rising edge starts soft start
lft_spd  out  SPD_W  unsigned left speed
lft_rev  out  1  left reverse
rght_spd  out  SPD_W  unsigned right speed
rght_rev  out  1  right reverse
out_vld  out  1  one-cycle strobe: outputs updated
too_fast  out  1  debounced overspeed
ramp_done  out  1  soft start complete (state RUN)

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low. On reset, all outputs and registers are 0 and the FSM is OFF.
- Stage 1, registered on vld:
  - ptch_err saturated to 10-bit signed [-512, 511].
  - P term = err*P_COEFF.
  - D diff = err - err from D_DEPTH vld samples earlier (history shift register, reset to 0), saturated to 7-bit signed [-64, 63], times D_COEFF.
  - Integrator: integ + sext(err), clamped to [-2^(INTEG_W-1), 2^(INTEG_W-1)-1]. On overflow it clamps; it does not hold.
  - rider_off=1 forces integ to 0 on the next clk regardless of vld; it has priority over vld.
- Stage 2, one cycle after stage 1:
  - PID = P + D + (integ>>>I_SHIFT), 16-bit signed.
  - Torque: lft = PID - (ld_cell_diff>>>3) and rght = PID + (ld_cell_diff>>>3) when en_steer=1; both equal PID otherwise.
  - Shaping: if |torque| >= LOW_TORQUE_BAND, output is torque ± MIN_DUTY (sign of torque). Otherwise it is torque*GAIN_MULT.
  - rev = sign of the shaped value.
  - Magnitude saturated to 2^SPD_W-1, then limited to min(magnitude, spd_limit).
- Latency and handshake: outputs and out_vld update exactly 2 clk after vld. Outputs hold between updates. A vld on back-to-back cycles is legal and fully pipelined.
- Soft-start FSM states:
  - OFF: spd_limit=0, speeds 0, ramp_done=0.
  - OFF -> RAMP on pwr_up=1.
  - RAMP: on each vld, spd_limit += RAMP_STEP, saturating at max speed. When spd_limit reaches max -> RUN.
  - RUN: ramp_done=1, spd_limit=max.
  - pwr_up=0 in any state -> OFF next clk. spd_limit=0 and the speed outputs read 0 the same clk; rev is held.
- too_fast:
  - Counter increments on each out_vld with lft_spd>TF_THRESH or rght_spd>TF_THRESH, else resets.
  - Set after TF_CNT consecutive over-threshold samples.
  - Clear after TF_CNT consecutive samples with both speeds at or below threshold, using a separate counter.
  - Cleared immediately in OFF.
- Boundaries:
  - ptch=0x8000 saturates to err=-512.
  - Integrator pinned at the clamp stays pinned until err reverses sign.
  - vld coinciding with pwr_up rising edge is processed; the ramp starts counting from that vld.
  - Reset mid-ramp returns to OFF.

Optional Feature:
BAL_INTEG_LEAK_EN:
- Defined: on every vld the integrator update is integ + err - (integ>>>10), clamp still applied, so the integrator decays toward 0 under zero error.
- Undefined: pure clamped accumulation, no leak.

Decomposition:
- Package balance_pkg holds:
  - FSM enum (OFF, RAMP, RUN)
  - default coefficient constants
  - saturation width constants
  - a signed saturate function
- One natural sub-module, torque_shaper: band test, MIN_DUTY/GAIN_MULT shaping, abs, sat, spd_limit clamp. It is instantiated twice (left, right).

Test Plan:
- Reset mid-run: assert rst_n=0 -> all outputs 0, FSM OFF, too_fast=0, integrator 0.
- Low-band case: pwr_up held until RUN, rider_off=1, en_steer=0, ptch=2 for 4 vld -> lft_spd=rght_spd=420, rev=0. Then ptch=-2 for 4 vld -> spd=420, rev=1. Each update lands 2 clk after vld.
- Band case: RUN, rider_off=1, ptch=20 steady 4 vld -> spd=1260 (280+980), too_fast=0. Then ptch=200 -> spd saturates at 2047. too_fast sets on the 4th consecutive out_vld, not the 3rd.
- Soft start: rider_off=1, ptch=20 steady, pwr_up rises -> spd=64k after k-th vld until k=20 (1280 caps to 1260). ramp_done=1 after the 32nd vld. pwr_up drops -> spd=0 next clk.
- Integrator clamp: rider_off=0, ptch=0x7FFF for 600 vld -> integ pinned at 131071 (INTEG_W=18), no wrap. Then rider_off=1 -> integ=0 next clk.
- Steering: en_steer=1, ld_cell_diff=+800, PID steady 280 -> lft torque 180, rght 380 -> lft_spd=1160, rght_spd=1360.
